// File: rtl/kbd_pkg.sv
// Shared definitions for the keypad number-entry block: ASCII key codes,
// controller state encoding and the latched-key record.
package kbd_pkg;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_ENTER = 8'h0D;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_POP  = 2'd1,
        S_EXEC = 2'd2,
        S_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        K_NONE  = 2'd0,
        K_DIGIT = 2'd1,
        K_BS    = 2'd2,
        K_ENTER = 2'd3
    } key_class_e;

    typedef struct packed {
        logic [7:0] code;
        logic       released;
        logic       err;
    } key_t;

    // Release events and corrupted codes fold into K_NONE so they are
    // discarded exactly like an unrecognised key.
    function automatic key_class_e classify(input key_t k);
        key_class_e c;
        c = K_NONE;
        if (!k.released && !k.err) begin
            if (k.code >= ASCII_0 && k.code <= ASCII_9) c = K_DIGIT;
            else if (k.code == ASCII_BS)                c = K_BS;
            else if (k.code == ASCII_ENTER)             c = K_ENTER;
        end
        return c;
    endfunction

endpackage

// File: rtl/bcd3_to_bin.sv
// Combinational conversion of three packed BCD digits {d2,d1,d0} to binary.
// Inputs are assumed to be valid BCD, so the result never exceeds 999.
module bcd3_to_bin (
    input  logic [11:0] bcd,
    output logic [9:0]  bin
);

    logic [9:0] d2;
    logic [9:0] d1;
    logic [9:0] d0;

    assign d2 = {6'd0, bcd[11:8]};
    assign d1 = {6'd0, bcd[7:4]};
    assign d0 = {6'd0, bcd[3:0]};

    // d2*100 = d2*(64+32+4), d1*10 = d1*(8+2): shift-add instead of multipliers.
    assign bin = (d2 << 6) + (d2 << 5) + (d2 << 2)
               + (d1 << 3) + (d1 << 1)
               + d0;

endmodule

// File: rtl/kbd_num_entry.sv
// Collects up to three decimal digits from a PS/2 ASCII decoder into a BCD
// display register and commits the binary value to the CPU on ENTER.
module kbd_num_entry
    import kbd_pkg::*;
#(
    parameter int MAX_DIGITS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  kbd_code,
    input  logic        kbd_ready,
    input  logic        kbd_released,
    input  logic        kbd_err,
    output logic        kbd_read,
    input  logic        clr,
    input  logic        cpu_ack,
    output logic [11:0] bcd,
    output logic [1:0]  digit_cnt,
    output logic [9:0]  value,
    output logic        value_valid
);

    localparam logic [1:0] CNT_MAX = 2'(MAX_DIGITS);

    state_e      state_q, state_d;
    key_t        key_q, key_d;
    logic [11:0] bcd_q, bcd_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [9:0]  value_q, value_d;
    logic        read_prev_q;
    logic [9:0]  bin_w;

    bcd3_to_bin u_bcd3_to_bin (
        .bcd (bcd_q),
        .bin (bin_w)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d  = state_q;
        key_d    = key_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        value_d  = value_q;
        kbd_read = 1'b0;

        unique case (state_q)
            S_WAIT: begin
                if (kbd_ready) begin
                    key_d   = '{code: kbd_code, released: kbd_released, err: kbd_err};
                    state_d = S_POP;
                end
            end

            S_POP: begin
                kbd_read = 1'b1;
                state_d  = S_EXEC;
            end

            S_EXEC: begin
                state_d = S_WAIT;
                unique case (classify(key_q))
                    K_DIGIT: begin
                        if (cnt_q < CNT_MAX) begin
                            bcd_d = {bcd_q[7:0], key_q.code[3:0]};
                            cnt_d = cnt_q + 2'd1;
                        end
                    end
                    K_BS: begin
                        if (cnt_q != 2'd0) begin
                            bcd_d = {4'h0, bcd_q[11:4]};
                            cnt_d = cnt_q - 2'd1;
                        end
                    end
                    K_ENTER: begin
                        if (cnt_q != 2'd0) begin
                            value_d = bin_w;
                            state_d = S_DONE;
                        end
                    end
                    default: ;
                endcase
            end

            S_DONE: begin
                // Keys arriving while the CPU owns the value are drained, but
                // never with two back-to-back pops.
                kbd_read = kbd_ready && !read_prev_q;
                if (cpu_ack) begin
                    bcd_d   = '0;
                    cnt_d   = '0;
                    value_d = '0;
                    state_d = S_WAIT;
                end
            end

            default: state_d = S_WAIT;
        endcase

        // Abort outranks acknowledge and key handling; a pop already in
        // progress still completes so the aborted key is not re-read.
        if (clr) begin
            state_d = S_WAIT;
            key_d   = '0;
            bcd_d   = '0;
            cnt_d   = '0;
            value_d = '0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values; all registers, including the latched key,
    // are cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_WAIT;
            key_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            value_q     <= '0;
            read_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            value_q     <= value_d;
            read_prev_q <= kbd_read;
        end
    end

    assign bcd         = bcd_q;
    assign digit_cnt   = cnt_q;
    assign value       = value_q;
    assign value_valid = (state_q == S_DONE);

endmodule
